// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core types and constants
package riscv_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HELD,
    S_DROP
  } if_state_t;

  // Opcodes shared with the CONTROL decoder (IFID_INSTRUCTION[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with skid buffer and redirect handling
module if_stage
  import riscv_pkg::*;
#(
  parameter int                TAM_PC   = 32,
  parameter int                TAM_INS  = 32,
  parameter logic [TAM_PC-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               RST_N,
  output logic               IMEM_REQ,
  output logic [TAM_PC-1:0]  IMEM_ADDR,
  input  logic               IMEM_ACK,
  input  logic [TAM_INS-1:0] IMEM_DATA,
  input  logic               STALL,
  input  logic               REDIRECT,
  input  logic [TAM_PC-1:0]  REDIRECT_PC,
  output logic               IFID_VALID,
  output logic [TAM_PC-1:0]  IFID_PC,
  output logic [TAM_INS-1:0] IFID_INSTRUCTION
);

  localparam logic [TAM_PC-1:0] ALIGN_MASK = ~TAM_PC'(3);

  if_state_t          state;
  logic [TAM_PC-1:0]  pc;
  logic [TAM_PC-1:0]  req_addr;
  logic [TAM_PC-1:0]  skid_pc;
  logic [TAM_INS-1:0] skid_instr;
  logic [TAM_PC-1:0]  redirect_target;
  logic [TAM_PC-1:0]  pc_inc;

  assign redirect_target = REDIRECT_PC & ALIGN_MASK;
  assign pc_inc          = pc + TAM_PC'(4);

  // S_DROP keeps presenting the abandoned address until memory answers it
  assign IMEM_REQ  = (state == S_REQ) || (state == S_DROP);
  assign IMEM_ADDR = (state == S_DROP) ? req_addr : pc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state            <= S_IDLE;
      pc               <= RESET_PC & ALIGN_MASK;
      req_addr         <= '0;
      skid_pc          <= '0;
      skid_instr       <= '0;
      IFID_VALID       <= 1'b0;
      IFID_PC          <= '0;
      IFID_INSTRUCTION <= TAM_INS'(NOP);
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          if (REDIRECT) begin
            IFID_VALID       <= 1'b0;
            IFID_PC          <= '0;
            IFID_INSTRUCTION <= TAM_INS'(NOP);
            pc               <= redirect_target;
          end else if (!STALL) begin
            IFID_VALID <= 1'b0;
          end
        end

        S_REQ: begin
          req_addr <= pc;
          if (REDIRECT) begin
            IFID_VALID       <= 1'b0;
            IFID_PC          <= '0;
            IFID_INSTRUCTION <= TAM_INS'(NOP);
            pc               <= redirect_target;
            if (!IMEM_ACK) state <= S_DROP;
          end else if (IMEM_ACK && (!STALL || !IFID_VALID)) begin
            IFID_VALID       <= 1'b1;
            IFID_PC          <= pc;
            IFID_INSTRUCTION <= IMEM_DATA;
            pc               <= pc_inc;
          end else if (IMEM_ACK) begin
            skid_pc    <= pc;
            skid_instr <= IMEM_DATA;
            pc         <= pc_inc;
            state      <= S_HELD;
          end else if (!STALL) begin
            IFID_VALID <= 1'b0;
          end
        end

        S_HELD: begin
          if (REDIRECT) begin
            IFID_VALID       <= 1'b0;
            IFID_PC          <= '0;
            IFID_INSTRUCTION <= TAM_INS'(NOP);
            skid_pc          <= '0;
            skid_instr       <= '0;
            pc               <= redirect_target;
            state            <= S_REQ;
          end else if (!STALL) begin
            IFID_VALID       <= 1'b1;
            IFID_PC          <= skid_pc;
            IFID_INSTRUCTION <= skid_instr;
            state            <= S_REQ;
          end
        end

        S_DROP: begin
          if (IMEM_ACK) state <= S_REQ;
          if (REDIRECT) begin
            IFID_VALID       <= 1'b0;
            IFID_PC          <= '0;
            IFID_INSTRUCTION <= TAM_INS'(NOP);
            pc               <= redirect_target;
          end else if (!STALL) begin
            IFID_VALID <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage against a behavioural model
module tb_if_stage;

  localparam logic [31:0] NOP_I = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IMEM_ACK = 1'b0;
  logic        STALL = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] IMEM_DATA = '0;
  logic [31:0] REDIRECT_PC = '0;
  logic        IMEM_REQ;
  logic        IFID_VALID;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_INSTRUCTION;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Model: next fetch address, a possibly abandoned request, fetched-but-undelivered words, and IF/ID
  logic [31:0] m_pc, m_stale_addr, m_ipc, m_ins;
  bit          m_started, m_stale, m_v;
  fetch_t      pend[$];

  always #5 CLK = ~CLK;

  if_stage #(.TAM_PC(32), .TAM_INS(32), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
    .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .IFID_VALID(IFID_VALID), .IFID_PC(IFID_PC), .IFID_INSTRUCTION(IFID_INSTRUCTION)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 5) | 32'h13;
  endfunction

  function automatic bit exp_req();
    return m_started && (pend.size() == 0);
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_stale ? m_stale_addr : m_pc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_flush();
    m_v = 0; m_ipc = '0; m_ins = NOP_I;
  endtask

  task automatic model_reset();
    m_pc = '0; m_started = 0; m_stale = 0; m_stale_addr = '0;
    pend.delete();
    model_flush();
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    bit          ack;
    tgt = REDIRECT_PC & ~32'h3;
    ack = IMEM_ACK && exp_req();
    if (!RST_N) begin
      model_reset();
    end else if (!m_started) begin
      m_started = 1;
      if (REDIRECT) begin model_flush(); m_pc = tgt; end
      else if (!STALL) m_v = 0;
    end else if (m_stale) begin
      if (ack) m_stale = 0;
      if (REDIRECT) begin model_flush(); m_pc = tgt; end
      else if (!STALL) m_v = 0;
    end else if (pend.size() != 0) begin
      if (REDIRECT) begin model_flush(); pend.delete(); m_pc = tgt; end
      else if (!STALL) begin
        m_v = 1; m_ipc = pend[0].pc; m_ins = pend[0].ins;
        pend.delete();
      end
    end else begin
      if (REDIRECT) begin
        model_flush();
        if (!ack) begin m_stale = 1; m_stale_addr = m_pc; end
        m_pc = tgt;
      end else if (ack) begin
        if (!STALL || !m_v) begin m_v = 1; m_ipc = m_pc; m_ins = mem_word(m_pc); end
        else pend.push_back(fetch_t'{pc: m_pc, ins: mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end else if (!STALL) begin
        m_v = 0;
      end
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("imem_req", 32'(IMEM_REQ), 32'(exp_req()));
      if (exp_req()) check("imem_addr", IMEM_ADDR, exp_addr());
      check("ifid_valid", 32'(IFID_VALID), 32'(m_v));
      check("ifid_pc", IFID_PC, m_ipc);
      check("ifid_instr", IFID_INSTRUCTION, m_ins);
    end
  end

  // Called just after a falling edge; returns just after the next falling edge
  task automatic cyc(input bit ack, input bit stall, input bit redir, input logic [31:0] tgt);
    IMEM_ACK    = ack;
    IMEM_DATA   = mem_word(IMEM_ADDR);
    STALL       = stall;
    REDIRECT    = redir;
    REDIRECT_PC = tgt;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    check("rst_req", 32'(IMEM_REQ), 32'd0);
    check("rst_valid", 32'(IFID_VALID), 32'd0);
    check("rst_pc", IFID_PC, 32'h0);
    check("rst_instr", IFID_INSTRUCTION, NOP_I);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return $urandom & 32'h0000_3FFF;
  endfunction

  initial begin
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    chk_en = 1;
    check("init_req", 32'(IMEM_REQ), 32'd0);
    check("init_instr", IFID_INSTRUCTION, NOP_I);
    RST_N = 1'b1;

    // zero-wait streaming
    cyc(1, 0, 0, 0);
    check("first_req", 32'(IMEM_REQ), 32'd1);
    check("first_addr", IMEM_ADDR, 32'h0);
    cyc(1, 0, 0, 0);
    check("stream_addr4", IMEM_ADDR, 32'h4);
    check("stream_ifid0", IFID_PC, 32'h0);
    check("stream_ins0", IFID_INSTRUCTION, 32'h13);
    cyc(1, 0, 0, 0);
    check("stream_addr8", IMEM_ADDR, 32'h8);
    check("stream_ifid4", IFID_PC, 32'h4);

    // three wait states at 0x8
    repeat (3) cyc(0, 0, 0, 0);
    check("wait_addr", IMEM_ADDR, 32'h8);
    check("wait_bubble", 32'(IFID_VALID), 32'd0);
    cyc(1, 0, 0, 0);
    check("wait_done_pc", IFID_PC, 32'h8);
    check("wait_next_addr", IMEM_ADDR, 32'hC);

    // stall while 0x10 returns
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    check("held_req", 32'(IMEM_REQ), 32'd0);
    check("held_ifid", IFID_PC, 32'hC);
    cyc(1, 1, 0, 0);
    check("held_ifid2", IFID_PC, 32'hC);
    cyc(1, 0, 0, 0);
    check("skid_pc", IFID_PC, 32'h10);
    check("skid_ins", IFID_INSTRUCTION, 32'h213);
    check("resume_addr", IMEM_ADDR, 32'h14);
    cyc(1, 0, 0, 0);
    check("resume_ifid", IFID_PC, 32'h14);

    // redirect with same-cycle ack at 0x20
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("pre_redir_addr", IMEM_ADDR, 32'h20);
    cyc(1, 0, 1, 32'h100);
    check("flush_valid", 32'(IFID_VALID), 32'd0);
    check("flush_instr", IFID_INSTRUCTION, NOP_I);
    check("redir_addr", IMEM_ADDR, 32'h100);
    cyc(1, 0, 0, 0);
    check("redir_ifid", IFID_PC, 32'h100);

    // redirects while a request is outstanding
    cyc(1, 0, 1, 32'h40);
    cyc(0, 0, 1, 32'h200);
    check("drop_addr", IMEM_ADDR, 32'h40);
    check("drop_req", 32'(IMEM_REQ), 32'd1);
    cyc(0, 0, 1, 32'h300);
    check("drop_addr2", IMEM_ADDR, 32'h40);
    cyc(1, 0, 0, 0);
    check("drop_target", IMEM_ADDR, 32'h300);
    check("drop_valid", 32'(IFID_VALID), 32'd0);
    cyc(1, 0, 0, 0);
    check("drop_ifid", IFID_PC, 32'h300);

    // misaligned target and wrap-around
    cyc(1, 0, 1, 32'hFFFF_FFFE);
    check("align_addr", IMEM_ADDR, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    check("wrap_addr", IMEM_ADDR, 32'h0);

    // reset mid-request, then in the held state with STALL=1
    cyc(0, 0, 0, 0);
    do_reset();
    cyc(1, 0, 0, 0);
    check("restart_addr", IMEM_ADDR, 32'h0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    check("held_before_rst", 32'(IMEM_REQ), 32'd0);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
               $urandom_range(0, 99) < 8, rand_target());
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
